spi_frame_receiver: RTL and testbench

- SPI slave front end (mode 0: CPOL=0, CPHA=0, MSB first), oversampled in the osc_clk domain.
- Captures fixed-length 360-bit MOSI frames and presents them as a stable parallel word `mosi_data[359:0]`.
- Directly feeds the PLL/difficulty configuration stage and the job-loading logic.
- Also shifts a 32-bit status/result word out on MISO during the same frame.

---
 rtl/spi_frame_pkg.sv | 33 +++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_frame_receiver.sv | 169 ++++++++++++++++
 tb/tb_spi_frame_receiver.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI frame receiver and the stages that consume its frame.
package spi_frame_pkg;

  // Default frame geometry
  localparam int unsigned FRAME_BITS_DEFAULT  = 360;
  localparam int unsigned MISO_BITS_DEFAULT   = 32;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  // Width of the received-bit counter; it saturates at all-ones
  localparam int unsigned CNT_W   = 9;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Field positions inside mosi_data for downstream consumers
  localparam int unsigned PLL_N_MSB      = 351;
  localparam int unsigned PLL_N_LSB      = 344;
  localparam int unsigned PLL_M_MSB      = 343;
  localparam int unsigned PLL_M_LSB      = 336;
  localparam int unsigned NONCE_DIFY_MSB = 335;
  localparam int unsigned NONCE_DIFY_LSB = 304;

  // Frame receiver state encoding
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StEnd   = 2'd2
  } spi_state_e;

  // Counter increment that sticks at CNT_MAX instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == CNT_MAX) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, plus one extra flop for edge detection.
module spi_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic osc_clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Shift the pin through the synchronizer chain and keep one delayed copy for edges
  always_ff @(posedge osc_clk or negedge reset) begin
    if (!reset) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 slave front end: captures a fixed-length MOSI frame into a held parallel word and
// shifts a response word out on MISO during the same frame. All SPI pins are oversampled.
module spi_frame_receiver
  import spi_frame_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = FRAME_BITS_DEFAULT,
  parameter int unsigned MISO_BITS   = MISO_BITS_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT  // must be at least 2
) (
  input  logic                  osc_clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  input  logic [MISO_BITS-1:0]  tx_word,
  output logic                  miso,
  output logic                  cs_sync_n,
  output logic [FRAME_BITS-1:0] mosi_data,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic                  busy,
  output logic [CNT_W-1:0]      bit_count
);

  localparam logic [CNT_W-1:0] FRAME_BITS_CNT = CNT_W'(FRAME_BITS);

  // Synchronized pins and edge strobes
  logic w_unused_sclk_level;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_mosi_sync;

  logic [SYNC_STAGES-1:0] r_mosi_sync;

  // Frame state
  spi_state_e            r_state;
  spi_state_e            w_state_next;
  logic [FRAME_BITS-1:0] r_shift_sr;
  logic [MISO_BITS-1:0]  r_miso_sr;
  logic [FRAME_BITS-1:0] r_mosi_data;
  logic [CNT_W-1:0]      r_bit_count;
  logic                  r_overflow;
  logic                  r_frame_good;
  logic                  r_cs_fall_pend;

  logic w_start;
  logic w_shift_active;
  logic w_frame_good;

  spi_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sclk_sync (
    .osc_clk (osc_clk),
    .reset   (reset),
    .i_async (sclk),
    .o_sync  (w_unused_sclk_level),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_cs_sync (
    .osc_clk (osc_clk),
    .reset   (reset),
    .i_async (cs_n),
    .o_sync  (cs_sync_n),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  // MOSI only needs a level; it has the same depth as sclk so data and its strobe stay aligned
  always_ff @(posedge osc_clk or negedge reset) begin
    if (!reset) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign w_mosi_sync = r_mosi_sync[SYNC_STAGES-1];

  // A chip-select fall seen during END is remembered and starts the frame in the next IDLE cycle
  assign w_start = (r_state == StIdle) && (w_cs_fall || r_cs_fall_pend);

  // cs_rise takes priority over any sclk edge in the same cycle
  assign w_shift_active = (r_state == StShift) && !w_cs_rise;

  assign w_frame_good = (r_bit_count == FRAME_BITS_CNT) && !r_overflow;

  // FSM state register
  always_ff @(posedge osc_clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_cs_fall || r_cs_fall_pend) w_state_next = StShift;
      StShift: if (w_cs_rise) w_state_next = StEnd;
      StEnd:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    frame_done  = (r_state == StEnd) && r_frame_good;
    frame_error = (r_state == StEnd) && !r_frame_good;
    busy        = (r_state == StShift);
    miso        = (r_state != StIdle) ? r_miso_sr[MISO_BITS-1] : 1'b0;
  end

  // Frame datapath: clear on start, shift on sclk edges, judge and commit the frame on cs_rise
  always_ff @(posedge osc_clk or negedge reset) begin
    if (!reset) begin
      r_shift_sr     <= '0;
      r_miso_sr      <= '0;
      r_mosi_data    <= '0;
      r_bit_count    <= '0;
      r_overflow     <= 1'b0;
      r_frame_good   <= 1'b0;
      r_cs_fall_pend <= 1'b0;
    end else begin
      r_cs_fall_pend <= (r_state == StEnd) && w_cs_fall;

      if (w_start) begin
        r_shift_sr  <= '0;
        r_miso_sr   <= tx_word;
        r_bit_count <= '0;
        r_overflow  <= 1'b0;
      end else if (w_shift_active) begin
        if (w_sclk_rise) begin
          // Bits beyond the frame length are counted but never shifted in
          if (r_bit_count == FRAME_BITS_CNT) begin
            r_overflow <= 1'b1;
          end else begin
            r_shift_sr <= {r_shift_sr[FRAME_BITS-2:0], w_mosi_sync};
          end
          r_bit_count <= sat_inc(r_bit_count);
        end
        if (w_sclk_fall) begin
          r_miso_sr <= {r_miso_sr[MISO_BITS-2:0], 1'b0};
        end
      end

      // Committed on entry to END so mosi_data is already new while frame_done is high
      if ((r_state == StShift) && w_cs_rise) begin
        r_frame_good <= w_frame_good;
        if (w_frame_good) begin
          r_mosi_data <= r_shift_sr;
        end
      end
    end
  end

  assign mosi_data = r_mosi_data;
  assign bit_count = r_bit_count;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Self-checking bench for spi_frame_receiver: drives SPI frames at osc_clk = 8x sclk and checks
// the frame outcome, held parallel word, live bit count and MISO stream against a frame model.
module tb_spi_frame_receiver;
  import spi_frame_pkg::*;

  localparam int FB = 360;
  localparam int MB = 32;
  localparam int SS = 2;

  logic          osc_clk = 1'b0;
  logic          reset   = 1'b0;
  logic          sclk    = 1'b0;
  logic          cs_n    = 1'b1;
  logic          mosi    = 1'b0;
  logic [MB-1:0] tx_word = '0;
  logic          miso;
  logic          cs_sync_n;
  logic [FB-1:0] mosi_data;
  logic          frame_done;
  logic          frame_error;
  logic          busy;
  logic [8:0]    bit_count;

  spi_frame_receiver #(
    .FRAME_BITS  (FB),
    .MISO_BITS   (MB),
    .SYNC_STAGES (SS)
  ) dut (
    .osc_clk     (osc_clk),
    .reset       (reset),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .tx_word     (tx_word),
    .miso        (miso),
    .cs_sync_n   (cs_sync_n),
    .mosi_data   (mosi_data),
    .frame_done  (frame_done),
    .frame_error (frame_error),
    .busy        (busy),
    .bit_count   (bit_count)
  );

  always #5 osc_clk = ~osc_clk;

  int unsigned cyc = 0;
  always @(posedge osc_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit done_all = 1'b0;

  // One entry per frame whose chip select has been released: bits sent, first FB bits, and the
  // cycle in which the cs_n pin rose
  typedef struct {
    int            n;
    logic [FB-1:0] frame;
    int unsigned   c_end;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          e;
  logic [FB-1:0] model_mosi = '0;

  task automatic check(input string name, input logic [FB-1:0] act, input logic [FB-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge osc_clk);
    #1;
  endtask

  function automatic logic [FB-1:0] rand_frame();
    logic [FB-1:0] f;
    for (int k = 0; k < FB; k++) f[k] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  // Compare process: outputs against the frame model on every falling edge
  always @(negedge osc_clk) begin
    if (!done_all) begin
      if (!reset) begin
        model_mosi = '0;
        check("rst_mosi_data", mosi_data, '0);
        check("rst_outputs", {frame_done, frame_error, busy, miso, cs_sync_n, bit_count},
              {4'b0000, 1'b1, 9'd0});
      end else if (frame_done || frame_error) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {frame_done, frame_error}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", {frame_done, frame_error}, (e.n == FB) ? 2'b10 : 2'b01);
          // The pin change is cycle 0; the pulse lands SYNC_STAGES+1 posedges later
          check("pulse_latency", cyc, e.c_end + SS + 1);
          check("end_bit_count", bit_count, (e.n > 511) ? 511 : e.n);
          check("end_busy", busy, 1'b0);
          if (e.n == FB) model_mosi = e.frame;
          check("mosi_data_end", mosi_data, model_mosi);
        end
      end else begin
        check("mosi_data_hold", mosi_data, model_mosi);
      end
    end
  end

  // One SPI frame of n bits; abort_at >= 0 pulls reset low at that bit instead of finishing
  task automatic run_frame(input int n, input logic [FB-1:0] frame, input logic [MB-1:0] tx,
                           input int gap, input int abort_at, output logic [MB-1:0] miso_word);
    logic exp_miso;
    miso_word = '0;
    tx_word   = tx;
    cs_n      = 1'b0;
    tick((n == 0) ? 200 : 16);
    tx_word = $urandom();  // must not affect a frame that has already started
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        reset = 1'b0;
        tick(6);
        cs_n = 1'b1;
        mosi = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(gap);
        return;
      end
      mosi = (i < FB) ? frame[FB-1-i] : 1'($urandom_range(0, 1));
      tick(4);
      check("bit_count_live", bit_count, (i > 511) ? 511 : i);
      check("busy_live", busy, 1'b1);
      exp_miso = (i < MB) ? tx[MB-1-i] : 1'b0;
      check("miso_bit", miso, exp_miso);
      if (i < MB) miso_word = {miso_word[MB-2:0], miso};
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    tick(4);
    cs_n = 1'b1;
    exp_q.push_back('{n, frame, cyc});
    tick(gap);
    if (gap >= 8) check("idle_miso_busy", {miso, busy}, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  logic [FB-1:0] fr;
  logic [MB-1:0] mw;
  int            lens[6] = '{360, 360, 360, 359, 361, 200};
  int            gaps[4] = '{1, 2, 8, 20};

  initial begin
    tick(4);
    reset = 1'b1;
    tick(4);

    // Good frame carrying known configuration fields and a known MISO word
    fr = rand_frame();
    fr[PLL_N_MSB:PLL_N_LSB]           = 8'h20;
    fr[PLL_M_MSB:PLL_M_LSB]           = 8'h02;
    fr[NONCE_DIFY_MSB:NONCE_DIFY_LSB] = 32'h0000FFFF;
    run_frame(360, fr, 32'hA5C3_0F01, 20, -1, mw);
    check("miso_readback", mw, 32'hA5C3_0F01);
    check("pll_n_field", mosi_data[PLL_N_MSB:PLL_N_LSB], 8'h20);
    check("pll_m_field", mosi_data[PLL_M_MSB:PLL_M_LSB], 8'h02);
    check("nonce_dify_field", mosi_data[NONCE_DIFY_MSB:NONCE_DIFY_LSB], 32'h0000FFFF);
    check("bit_count_final", bit_count, 9'd360);

    // Short, long, saturating and zero-length frames
    run_frame(200, rand_frame(), $urandom(), 20, -1, mw);
    run_frame(365, rand_frame(), $urandom(), 20, -1, mw);
    check("long_bit_count", bit_count, 9'd365);
    run_frame(515, rand_frame(), $urandom(), 20, -1, mw);
    run_frame(0, rand_frame(), $urandom(), 20, -1, mw);

    // Reset in the middle of a frame, then a normal frame
    run_frame(360, rand_frame(), $urandom(), 20, 100, mw);
    run_frame(360, rand_frame(), $urandom(), 20, -1, mw);

    // Back-to-back frames: one sclk period gap, then a single-cycle gap
    run_frame(360, rand_frame(), $urandom(), 8, -1, mw);
    run_frame(360, rand_frame(), $urandom(), 1, -1, mw);
    run_frame(360, rand_frame(), $urandom(), 20, -1, mw);

    // Randomized frames
    for (int r = 0; r < 6; r++) begin
      run_frame(lens[$urandom_range(0, 5)], rand_frame(), $urandom(),
                gaps[$urandom_range(0, 3)], -1, mw);
    end

    tick(20);
    check("pending_pulses", exp_q.size(), 0);
    done_all = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
